// File: rtl/riscv_su_stacking_engine.sv
// riscv_su_stacking_engine: interrupt frame stacking/unstacking engine below the stack pointer.
// Ports: clk/nreset (async active-low); enable, i_abort, i_irq_req, i_irq_ret, i_sp control the FSM;
// o_reg_idx/i_reg_rdata read the register file, o_reg_we/o_reg_wdata restore it;
// o_mem_* / i_mem_* form a single-outstanding memory port; o_sp_we/o_sp_new update SP;
// o_busy, o_done, o_fsm_status report state.
// Optional tail-chaining during unstack is built when RISCV_SU_TAIL_CHAIN_EN is defined.
module riscv_su_stacking_engine #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS     = 8,
  parameter int SU_FSM_WIDTH = 3,
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    enable,
  input  logic                    i_abort,
  input  logic                    i_irq_req,
  input  logic                    i_irq_ret,
  input  logic [ADDR_WIDTH-1:0]   i_sp,
  output logic [IW-1:0]           o_reg_idx,
  input  logic [DATA_WIDTH-1:0]   i_reg_rdata,
  output logic                    o_reg_we,
  output logic [DATA_WIDTH-1:0]   o_reg_wdata,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_ack,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_sp_we,
  output logic [ADDR_WIDTH-1:0]   o_sp_new,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [SU_FSM_WIDTH-1:0] o_fsm_status
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] FRAME = ADDR_WIDTH'(NUM_REGS * BYTES);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);
  typedef enum logic [2:0] {IDLE, STACK, ACTIVE, UNSTACK, DONE} state_e;
  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, ridx_q, ridx_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, sp_new_q, sp_new_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                  sp_we_q, sp_we_d, reg_we_q, reg_we_d, ack;
`ifdef RISCV_SU_TAIL_CHAIN_EN
  logic                  chain_q, chain_d, chain_now;
`endif
  assign o_busy       = state_q == STACK || state_q == UNSTACK;
  assign o_mem_req    = o_busy;
  assign o_mem_we     = state_q == STACK;
  assign o_mem_addr   = o_mem_req ? base_q + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(BYTES) : '0;
  assign o_mem_wdata  = o_mem_we ? i_reg_rdata : '0;
  // During a restore pulse the index shows the beat being written back, not the next read.
  assign o_reg_idx    = reg_we_q ? ridx_q : idx_q;
  assign o_reg_we     = reg_we_q;
  assign o_reg_wdata  = reg_wdata_q;
  assign o_sp_we      = sp_we_q;
  assign o_sp_new     = sp_new_q;
  assign o_done       = state_q == DONE;
  assign o_fsm_status = SU_FSM_WIDTH'(state_q);
  assign ack          = i_mem_ack & o_mem_req;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    ridx_d      = ridx_q;
    reg_wdata_d = reg_wdata_q;
    sp_new_d    = sp_new_q;
    sp_we_d     = 1'b0;
    reg_we_d    = 1'b0;
`ifdef RISCV_SU_TAIL_CHAIN_EN
    chain_d     = chain_q;
    chain_now   = chain_q | (enable & i_irq_req);
`endif
    case (state_q)
      IDLE: if (enable && i_irq_req) begin
        base_d  = i_sp - FRAME;
        idx_d   = '0;
        state_d = STACK;
      end
      STACK: if (ack) begin
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d    = '0;
          state_d  = ACTIVE;
          sp_we_d  = 1'b1;
          sp_new_d = base_q;
        end
      end
      ACTIVE: if (enable && i_irq_ret) begin
        base_d  = i_sp;
        idx_d   = '0;
        state_d = UNSTACK;
      end
      UNSTACK: begin
`ifdef RISCV_SU_TAIL_CHAIN_EN
        chain_d = chain_now;
`endif
        if (ack) begin
          reg_we_d    = 1'b1;
          reg_wdata_d = i_mem_rdata;
          ridx_d      = idx_q;
          idx_d       = idx_q + IW'(1);
`ifdef RISCV_SU_TAIL_CHAIN_EN
          // A pending chain ends the restore after this beat; the frame stays in memory.
          if (chain_now) begin
            idx_d   = '0;
            chain_d = 1'b0;
            state_d = ACTIVE;
          end else
`endif
          if (idx_q == LAST) begin
            idx_d    = '0;
            state_d  = DONE;
            sp_we_d  = 1'b1;
            sp_new_d = base_q + FRAME;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_abort) begin
      state_d  = IDLE;
      idx_d    = '0;
      sp_we_d  = 1'b0;
      reg_we_d = 1'b0;
`ifdef RISCV_SU_TAIL_CHAIN_EN
      chain_d  = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      ridx_q      <= '0;
      reg_wdata_q <= '0;
      sp_new_q    <= '0;
      sp_we_q     <= 1'b0;
      reg_we_q    <= 1'b0;
`ifdef RISCV_SU_TAIL_CHAIN_EN
      chain_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      ridx_q      <= ridx_d;
      reg_wdata_q <= reg_wdata_d;
      sp_new_q    <= sp_new_d;
      sp_we_q     <= sp_we_d;
      reg_we_q    <= reg_we_d;
`ifdef RISCV_SU_TAIL_CHAIN_EN
      chain_q     <= chain_d;
`endif
    end
  end
endmodule

// File: tb/tb_riscv_su_stacking_engine.sv
// tb_riscv_su_stacking_engine: scoreboard bench for the stacking engine with a behavioural memory.
module tb_riscv_su_stacking_engine;
  localparam int NR = 8;
  localparam logic [63:0] FRAME = 64'h40;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nreset, enable, i_abort, i_irq_req, i_irq_ret;
  logic [63:0] i_sp, i_reg_rdata, o_reg_wdata, o_mem_addr, o_mem_wdata, i_mem_rdata, o_sp_new;
  logic [2:0] o_reg_idx, o_fsm_status;
  logic o_reg_we, o_mem_req, o_mem_we, i_mem_ack, o_sp_we, o_busy, o_done;
  riscv_su_stacking_engine dut (
    .clk(clk), .nreset(nreset), .enable(enable), .i_abort(i_abort), .i_irq_req(i_irq_req),
    .i_irq_ret(i_irq_ret), .i_sp(i_sp), .o_reg_idx(o_reg_idx), .i_reg_rdata(i_reg_rdata),
    .o_reg_we(o_reg_we), .o_reg_wdata(o_reg_wdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_sp_we(o_sp_we), .o_sp_new(o_sp_new), .o_busy(o_busy),
    .o_done(o_done), .o_fsm_status(o_fsm_status)
  );
  logic [63:0] regs [NR];
  assign i_reg_rdata = regs[o_reg_idx];
  typedef struct {logic we; logic [63:0] addr; logic [63:0] data;} mem_t;
  typedef struct {int idx; logic [63:0] data;} reg_t;
  mem_t mq[$];
  reg_t rq[$];
  logic [63:0] spq[$];
  logic [63:0] mem [logic [63:0]];
  logic [63:0] exp_mem [logic [63:0]];
  int n_tests = 0, n_fail = 0;
  int ack_div = 1, ack_cnt = 0, hold = 0, beat = 0, stall_beat = -1;
  bit stall_done = 0, was_wait = 0, ack_now;
  logic [63:0] w_addr, w_data;
  mem_t me;
  reg_t re;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!o_mem_req) beat = 0;
    if (o_mem_req && beat == stall_beat && hold == 0 && !stall_done) begin
      hold = 10;
      stall_done = 1;
    end
    ack_now = o_mem_req && hold == 0 && ack_cnt >= ack_div - 1;
    if (o_mem_req && hold > 0) hold--;
    if (was_wait) begin
      chk("hold_req", o_mem_req, 1);
      chk("hold_addr", o_mem_addr, w_addr);
      chk("hold_wdata", o_mem_wdata, w_data);
    end
    was_wait = o_mem_req && !ack_now;
    w_addr = o_mem_addr;
    w_data = o_mem_wdata;
    i_mem_ack = ack_now;
    if (ack_now) begin
      if (mq.size() == 0) chk("mem_unexp", 1, 0);
      else begin
        me = mq.pop_front();
        chk("mem_we", o_mem_we, me.we);
        chk("mem_addr", o_mem_addr, me.addr);
        if (me.we) chk("mem_wdata", o_mem_wdata, me.data);
      end
      if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
      else i_mem_rdata = mem.exists(o_mem_addr) ? mem[o_mem_addr] : '0;
      beat++;
      ack_cnt = 0;
    end else if (o_mem_req) ack_cnt++;
    if (o_reg_we) begin
      if (rq.size() == 0) chk("reg_unexp", 1, 0);
      else begin
        re = rq.pop_front();
        chk("reg_idx", 64'(o_reg_idx), 64'(re.idx));
        chk("reg_wdata", o_reg_wdata, re.data);
      end
    end
    if (o_sp_we) begin
      if (spq.size() == 0) chk("sp_unexp", 1, 0);
      else chk("sp_new", o_sp_new, spq.pop_front());
    end
  end
  task automatic push_stack(input logic [63:0] sp);
    logic [63:0] b, a;
    b = sp - FRAME;
    for (int i = 0; i < NR; i++) begin
      regs[i] = {$urandom, $urandom};
      a = b + 64'(8 * i);
      mq.push_back('{we: 1'b1, addr: a, data: regs[i]});
      exp_mem[a] = regs[i];
    end
    spq.push_back(b);
  endtask
  task automatic push_unstack(input logic [63:0] sp, input int n, input bit with_sp);
    logic [63:0] a;
    for (int i = 0; i < n; i++) begin
      a = sp + 64'(8 * i);
      mq.push_back('{we: 1'b0, addr: a, data: exp_mem[a]});
      rq.push_back('{idx: i, data: exp_mem[a]});
    end
    if (with_sp) spq.push_back(sp + FRAME);
  endtask
  task automatic wait_status(input logic [2:0] s, input int max, output int n);
    n = 0;
    while (o_fsm_status !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_state", 64'(o_fsm_status), 64'(s));
  endtask
  task automatic do_stack(input logic [63:0] sp, input int lat, input string tag);
    int n;
    push_stack(sp);
    @(negedge clk);
    i_sp = sp;
    i_irq_req = 1;
    @(negedge clk);
    i_irq_req = 0;
    chk({tag, "_stack"}, 64'(o_fsm_status), 1);
    chk({tag, "_busy"}, o_busy, 1);
    wait_status(3'd2, 100, n);
    chk({tag, "_lat"}, 64'(n + 1), 64'(lat));
    chk({tag, "_sp_we"}, o_sp_we, 1);
    chk({tag, "_sp_new"}, o_sp_new, sp - FRAME);
  endtask
  task automatic do_unstack(input logic [63:0] sp, input int lat, input string tag);
    int n;
    push_unstack(sp, NR, 1);
    @(negedge clk);
    i_sp = sp;
    i_irq_ret = 1;
    @(negedge clk);
    i_irq_ret = 0;
    chk({tag, "_unstack"}, 64'(o_fsm_status), 3);
    wait_status(3'd4, 100, n);
    chk({tag, "_lat"}, 64'(n + 1), 64'(lat));
    chk({tag, "_done"}, o_done, 1);
    chk({tag, "_sp_new"}, o_sp_new, sp + FRAME);
    @(negedge clk);
    chk({tag, "_idle"}, 64'(o_fsm_status), 0);
    chk({tag, "_done_lo"}, o_done, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n;
    logic [63:0] b;
    nreset = 0; enable = 1; i_abort = 0; i_irq_req = 0; i_irq_ret = 0; i_sp = '0;
    i_mem_ack = 0; i_mem_rdata = '0;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(o_fsm_status), 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_sp_we", o_sp_we, 0);
    chk("rst_sp_new", o_sp_new, 0);
    chk("rst_reg_we", o_reg_we, 0);
    chk("rst_busy_done", {o_busy, o_done}, 0);
    nreset = 1;
    do_stack(64'h1000, 9, "t1");
    chk("t1_sp_lit", o_sp_new, 64'hFC0);
    ack_div = 3;
    do_unstack(64'hFC0, 25, "t2");
    chk("t2_sp_lit", o_sp_new, 64'h1000);
    ack_div = 1;
    stall_beat = 3;
    stall_done = 0;
    do_stack(64'h2000, 19, "t3");
    stall_beat = -1;
    do_unstack(64'h1FC0, 9, "t3u");
    b = 64'h4000 - FRAME;
    for (int i = 0; i < 5; i++) begin
      regs[i] = {$urandom, $urandom};
      mq.push_back('{we: 1'b1, addr: b + 64'(8 * i), data: regs[i]});
    end
    @(negedge clk);
    i_sp = 64'h4000;
    i_irq_req = 1;
    @(negedge clk);
    i_irq_req = 0;
    n = 0;
    while (o_mem_addr !== b + 64'd32 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_beat4", o_mem_addr, b + 64'd32);
    i_abort = 1;
    @(negedge clk);
    i_abort = 0;
    chk("t4_idle", 64'(o_fsm_status), 0);
    chk("t4_sp_we", o_sp_we, 0);
    chk("t4_req", o_mem_req, 0);
    do_stack(64'h20, 9, "t5");
    chk("t5_base", o_sp_new, 64'hFFFF_FFFF_FFFF_FFE0);
    do_unstack(64'hFFFF_FFFF_FFFF_FFE0, 9, "t5u");
    do_stack(64'h3000, 9, "t6");
`ifdef RISCV_SU_TAIL_CHAIN_EN
    push_unstack(64'h2FC0, 3, 0);
`else
    push_unstack(64'h2FC0, NR, 1);
`endif
    @(negedge clk);
    i_sp = 64'h2FC0;
    i_irq_ret = 1;
    @(negedge clk);
    i_irq_ret = 0;
    n = 0;
    while (o_mem_addr !== 64'h2FD0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_beat2", o_mem_addr, 64'h2FD0);
    i_irq_req = 1;
    i_sp = 64'h3000;
`ifdef RISCV_SU_TAIL_CHAIN_EN
    @(negedge clk);
    i_irq_req = 0;
    chk("t6_chain_active", 64'(o_fsm_status), 2);
    chk("t6_chain_sp_we", o_sp_we, 0);
    do_unstack(64'h2FC0, 9, "t6c");
`else
    push_stack(64'h3000);
    wait_status(3'd4, 50, n);
    chk("t6_done", o_done, 1);
    @(negedge clk);
    chk("t6_idle", 64'(o_fsm_status), 0);
    @(negedge clk);
    chk("t6_restack", 64'(o_fsm_status), 1);
    i_irq_req = 0;
    wait_status(3'd2, 50, n);
    chk("t6_sp_new", o_sp_new, 64'h2FC0);
    do_unstack(64'h2FC0, 9, "t6u");
`endif
    repeat (3) @(negedge clk);
    chk("mq_empty", 64'(mq.size()), 0);
    chk("rq_empty", 64'(rq.size()), 0);
    chk("spq_empty", 64'(spq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
